pipelined_nand_adder: RTL and testbench
=======================================

Name: pipelined_nand_adder

Overview:
- Parametrised, pipelined ripple-carry adder. It is the next generation of the team's 9-NAND full-adder bit slice: it generalises the single-bit combinational cell to WIDTH bits split across STAGES registered segments.
- Valid/ready streaming handshake with a whole-pipe stall, carry-in, carry-out and a mode-selected overflow flag.
- Sits in datapath blocks that need throughput of one add per clock at widths where a single ripple chain would miss timing.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of STAGES, minimum 2.
- STAGES, 4, number of pipeline segments and also the latency in cycles; range 1..WIDTH.
- SIGNED, 0, overflow mode: 0 = unsigned (ovf = cout), 1 = two's-complement (ovf = carry into MSB XOR carry out of MSB).

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst_n, input, 1, reset: synchronous, active-low.
- in_valid, input, 1, operands a/b/cin are presented this cycle.
- in_ready, output, 1, the pipe accepts operands this cycle.
- a, input, WIDTH, operand A.
- b, input, WIDTH, operand B.
- cin, input, 1, carry-in to bit 0.
- out_valid, output, 1, sum/cout/ovf hold a result.
- out_ready, input, 1, the consumer takes the result this cycle.
- sum, output, WIDTH, (a + b + cin) mod 2^WIDTH.
- cout, output, 1, carry out of bit WIDTH-1.
- ovf, output, 1, overflow per the SIGNED parameter.

Behaviour:
- Slicing: SEG = WIDTH/STAGES bits per segment. Segment k adds bits [k*SEG +: SEG] using a chain of NAND-form full adders (9 two-input NANDs per bit). Its carry-in is the registered carry from segment k-1; segment 0 uses cin.
- Skew: unprocessed upper operand bits and completed lower sum bits travel in pipeline registers alongside each valid bit v[k].
- Advance rule: stall = out_valid & ~out_ready. in_ready = ~stall. When stall is 0, every stage shifts by one. When stall is 1, all stages hold, including the valid bits.
- Bubbles: bubbles are not compressed. A gap at the input stays a gap at the output.
- Accept/complete: a transfer is in_valid & in_ready. A result completes on out_valid & out_ready.
- Latency: an operand accepted at edge t produces out_valid=1 after edge t+STAGES-1, i.e. visible STAGES cycles after acceptance, provided there are no stalls. Each stall cycle adds one cycle of latency.
- Throughput: one result per cycle while out_ready=1.
- Outputs: sum, cout and ovf come straight from final-stage registers, with no combinational path from the inputs. They stay stable while out_valid=1 and out_ready=0.
- Overflow: with SIGNED=0, ovf = cout. With SIGNED=1, ovf = c[WIDTH-1] ^ c[WIDTH]; the MSB carry-in is captured in the last segment.
- Wrap: sum is always taken modulo 2^WIDTH. cout=1 on unsigned wrap.
- Reset values: when rst_n=0 at a clock edge, all v[k] go to 0, out_valid=0, sum=0, cout=0, ovf=0. in_ready is 1 in the cycle after reset, because out_valid=0.
- Reset mid-operation: all in-flight results are dropped with no partial outputs. The first accept after reset behaves exactly as it would from power-up.
- Simultaneous events: when the pipe is full and the consumer takes a result (out_ready=1), a new input is accepted in the same cycle.
- Input during stall: in_valid while stalled is not accepted. The producer must hold a/b/cin.
- Out-of-range inputs: in_valid is ignored while rst_n=0.
- STAGES=1: degenerates to a single registered adder with latency 1.
- Elaboration check: fatal error if WIDTH % STAGES != 0.

Test Plan:
- Reset and single add: hold rst_n=0 for 2 cycles, then release. Apply a=0x1234, b=0x0FF1, cin=1 once. Required: out_valid=1 exactly 4 cycles after acceptance, with sum=0x2226, cout=0, ovf=0. Before that, out_valid=0 and sum=0.
- Streaming: send 32 random back-to-back vectors with out_ready held at 1. Required: 32 consecutive out_valid cycles, in order, each matching the reference a+b+cin; in_ready stays 1 throughout.
- Backpressure: with the pipe full, drop out_ready for 3 cycles. Required: in_ready=0 during those cycles, and sum/cout/ovf hold steady. No result is lost or duplicated, and order is preserved after release.
- Wrap and unsigned overflow: a=0xFFFF, b=0x0000, cin=1. Required: sum=0x0000, cout=1, ovf=1 (SIGNED=0).
- Signed overflow (SIGNED=1): a=0x7FFF, b=0x0001, cin=0 gives sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x8000 gives sum=0x0000, cout=1, ovf=1. Then a=0xFFFF, b=0x0001 gives cout=1, ovf=0.
- Reset mid-flight: accept 3 vectors, then assert rst_n=0 for 1 cycle. Required: out_valid=0 and outputs=0 with none of the 3 results emerging. A new vector then returns after 4 cycles. Repeat the run with WIDTH=8, STAGES=1 and WIDTH=8, STAGES=8.

Source files
------------

// File: rtl/pipelined_nand_adder.sv
// Pipelined ripple-carry adder built from 9-NAND full-adder slices, with a
// valid/ready handshake and a whole-pipe stall.
module pipelined_nand_adder #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4,
  parameter bit          SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned SEG = WIDTH / STAGES;

  if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
    $fatal(1, "pipelined_nand_adder: WIDTH must be >= 2 and a multiple of STAGES (1..WIDTH)");
  end

  // Full adder in the classic nine two-input NAND form; returns {carry, sum}.
  function automatic logic [1:0] nand_fa(input logic x, input logic y, input logic ci);
    logic n1, n2, n3, n4, n5, n6, n7;
    n1 = ~(x & y);
    n2 = ~(x & n1);
    n3 = ~(y & n1);
    n4 = ~(n2 & n3);
    n5 = ~(n4 & ci);
    n6 = ~(n4 & n5);
    n7 = ~(ci & n5);
    return {~(n1 & n5), ~(n6 & n7)};
  endfunction

  logic stall;
  logic advance;

  assign stall    = out_valid & ~out_ready;
  assign advance  = ~stall;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LO = k * SEG;
    localparam int unsigned HI = LO + SEG;

    // Operand bits not yet summed, with bit LO at index 0.
    logic [WIDTH-LO-1:0] a_src;
    logic [WIDTH-LO-1:0] b_src;
    logic                v_in;
    logic                c_in;
    logic [SEG-1:0]      seg_s;
    logic [SEG:0]        c;
    logic [HI-1:0]       s_d;

    logic                v_q;
    logic                c_q;
    logic [HI-1:0]       s_q;

    if (k == 0) begin : g_src
      assign v_in  = in_valid;
      assign c_in  = cin;
      assign a_src = a;
      assign b_src = b;
      assign s_d   = seg_s;
    end else begin : g_src
      assign v_in  = g_stage[k-1].v_q;
      assign c_in  = g_stage[k-1].c_q;
      assign a_src = g_stage[k-1].g_fwd.a_q;
      assign b_src = g_stage[k-1].g_fwd.b_q;
      assign s_d   = {seg_s, g_stage[k-1].s_q};
    end

    always_comb begin
      seg_s = '0;
      c[0]  = c_in;
      for (int i = 0; i < int'(SEG); i++) begin
        {c[i+1], seg_s[i]} = nand_fa(a_src[i], b_src[i], c[i]);
      end
    end

    // Data only loads with a valid token, so bubbles leave the last result in place.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (advance) begin
        v_q <= v_in;
        if (v_in) begin
          c_q <= c[SEG];
          s_q <= s_d;
        end
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [WIDTH-HI-1:0] a_q;
      logic [WIDTH-HI-1:0] b_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance && v_in) begin
          a_q <= a_src[WIDTH-LO-1:SEG];
          b_q <= b_src[WIDTH-LO-1:SEG];
        end
      end
    end else begin : g_last
      logic ovf_q;

      // c[SEG-1] is the carry into the MSB of the whole word.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (advance && v_in) begin
          ovf_q <= SIGNED ? (c[SEG-1] ^ c[SEG]) : c[SEG];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign sum       = g_stage[STAGES-1].s_q;
  assign cout      = g_stage[STAGES-1].c_q;
  assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_nand_adder.sv
// Bench for pipelined_nand_adder: four configurations share one stimulus bus,
// a select picks the active one, and a queue-based model checks every result.
module tb_pipelined_nand_adder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic        cin;
  logic [15:0] a;
  logic [15:0] b;
  int          sel;

  logic [3:0]  ir, ov, co, of;
  logic [15:0] s0, s1;
  logic [7:0]  s2, s3;

  int tests = 0;
  int fails = 0;
  int n_done = 0;
  logic last_acc = 1'b0;
  logic [17:0] q[$];

  pipelined_nand_adder #(.WIDTH(16), .STAGES(4), .SIGNED(1'b0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 0), .in_ready(ir[0]),
    .a(a), .b(b), .cin(cin), .out_valid(ov[0]), .out_ready(out_ready || sel != 0),
    .sum(s0), .cout(co[0]), .ovf(of[0]));

  pipelined_nand_adder #(.WIDTH(16), .STAGES(4), .SIGNED(1'b1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 1), .in_ready(ir[1]),
    .a(a), .b(b), .cin(cin), .out_valid(ov[1]), .out_ready(out_ready || sel != 1),
    .sum(s1), .cout(co[1]), .ovf(of[1]));

  pipelined_nand_adder #(.WIDTH(8), .STAGES(1), .SIGNED(1'b0)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 2), .in_ready(ir[2]),
    .a(a[7:0]), .b(b[7:0]), .cin(cin), .out_valid(ov[2]), .out_ready(out_ready || sel != 2),
    .sum(s2), .cout(co[2]), .ovf(of[2]));

  pipelined_nand_adder #(.WIDTH(8), .STAGES(8), .SIGNED(1'b0)) u_d3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 3), .in_ready(ir[3]),
    .a(a[7:0]), .b(b[7:0]), .cin(cin), .out_valid(ov[3]), .out_ready(out_ready || sel != 3),
    .sum(s3), .cout(co[3]), .ovf(of[3]));

  logic        o_valid, o_ready, o_cout, o_ovf;
  logic [15:0] o_sum;

  always_comb begin
    o_valid = ov[sel[1:0]];
    o_ready = ir[sel[1:0]];
    o_cout  = co[sel[1:0]];
    o_ovf   = of[sel[1:0]];
    case (sel)
      0:       o_sum = s0;
      1:       o_sum = s1;
      2:       o_sum = {8'h00, s2};
      default: o_sum = {8'h00, s3};
    endcase
  end

  function automatic int stages_of(input int s);
    case (s)
      0, 1:    return 4;
      2:       return 1;
      default: return 8;
    endcase
  endfunction

  // Reference: plain arithmetic on the configured width; returns {ovf, cout, sum}.
  function automatic logic [17:0] model(input int s, input logic [15:0] aa,
                                        input logic [15:0] bb, input logic ci);
    logic [16:0] full;
    logic [15:0] mask, r;
    logic        carry, sa, sb, sr, v;
    mask = (s >= 2) ? 16'h00FF : 16'hFFFF;
    full = {1'b0, aa & mask} + {1'b0, bb & mask} + {16'd0, ci};
    if (s >= 2) begin
      r = {8'h00, full[7:0]};
      carry = full[8];
      sa = aa[7]; sb = bb[7]; sr = r[7];
    end else begin
      r = full[15:0];
      carry = full[16];
      sa = aa[15]; sb = bb[15]; sr = r[15];
    end
    v = (s == 1) ? (sa == sb && sr != sa) : carry;
    return {v, carry, r};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (sel %0d, t=%0t)", name, got, exp, sel, $time);
    end
  endtask

  // Scoreboard: pushes on accept, compares the head whenever a result is shown.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      last_acc = 1'b0;
    end else begin
      if (o_valid) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_result: got %h with no outstanding operation (sel %0d, t=%0t)",
                   {o_ovf, o_cout, o_sum}, sel, $time);
        end else begin
          if ({o_ovf, o_cout, o_sum} !== q[0]) begin
            fails++;
            $display("FAIL result: got %h, expected %h (sel %0d, t=%0t)",
                     {o_ovf, o_cout, o_sum}, q[0], sel, $time);
          end
          if (out_ready) begin
            void'(q.pop_front());
            n_done++;
          end
        end
      end
      last_acc = in_valid && o_ready;
      if (last_acc) q.push_back(model(sel, a, b, cin));
    end
  end

  // Presents one operand set and returns the edge count until out_valid.
  task automatic apply_one(input logic [15:0] aa, input logic [15:0] bb, input logic ci,
                           output int lat);
    a = aa; b = bb; cin = ci; in_valid = 1'b1; out_ready = 1'b1; lat = 0;
    do begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat++;
    end while (!o_valid && lat < 40);
  endtask

  task automatic drain(input string name);
    int k = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while (q.size() != 0 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check(name, q.size(), 0);
  endtask

  // Back-to-back random stream; out_ready drops for stall_len cycles from stall_at.
  task automatic stream(input int n, input int stall_at, input int stall_len);
    int sent = 0;
    int cyc = 0;
    int done0 = n_done;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); in_valid = 1'b1;
    while (sent < n && cyc < 500) begin
      out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      #1;
      check("in_ready", 32'(o_ready), 32'(out_ready));
      @(posedge clk); #1;
      cyc++;
      if (last_acc) begin
        sent++;
        if (sent < n) begin
          a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    drain("stream_drain");
    check("stream_count", n_done - done0, n);
  endtask

  task automatic midflight_reset(input int s);
    int lat;
    logic [15:0] na, nb;
    sel = s;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); in_valid = 1'b1;
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    check("rst_mid_valid", 32'(o_valid), 0);
    check("rst_mid_outs", {o_ovf, o_cout, o_sum}, 0);
    repeat (10) begin
      @(posedge clk); #1;
      check("rst_mid_quiet", 32'(o_valid), 0);
    end
    na = 16'($urandom); nb = 16'($urandom);
    apply_one(na, nb, 1'b1, lat);
    check("rst_mid_latency", lat, stages_of(s));
    check("rst_mid_result", {o_ovf, o_cout, o_sum}, model(s, na, nb, 1'b1));
    drain("rst_mid_drain");
  endtask

  typedef struct {
    int          s;
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [15:0] sum;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int lat;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cin = 1'b0; a = '0; b = '0; sel = 0;

    tbl[0] = '{0, 16'h1234, 16'h0FF1, 1'b1, 16'h2226, 1'b0, 1'b0};
    tbl[1] = '{0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1};
    tbl[2] = '{0, 16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1};
    tbl[3] = '{1, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[4] = '{1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[5] = '{1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[6] = '{2, 16'h00FF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[7] = '{3, 16'h007F, 16'h0001, 1'b1, 16'h0081, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1;
      check("reset_valid", 32'(o_valid), 0);
      check("reset_outs", {o_ovf, o_cout, o_sum}, 0);
      check("reset_in_ready", 32'(o_ready), 1);
      @(posedge clk); #1;
    end

    for (int i = 0; i < 8; i++) begin
      sel = tbl[i].s;
      apply_one(tbl[i].a, tbl[i].b, tbl[i].ci, lat);
      check($sformatf("vec%0d_latency", i), lat, stages_of(tbl[i].s));
      check($sformatf("vec%0d_result", i), {o_ovf, o_cout, o_sum},
            {14'd0, tbl[i].ov, tbl[i].co, tbl[i].sum});
      drain("vec_drain");
    end

    sel = 0; stream(32, 1000, 0);
    sel = 1; stream(16, 1000, 0);
    sel = 2; stream(16, 1000, 0);
    sel = 3; stream(16, 1000, 0);

    sel = 0; stream(20, 8, 3);
    sel = 3; stream(20, 16, 3);
    sel = 2; stream(10, 4, 2);

    midflight_reset(0);
    midflight_reset(2);
    midflight_reset(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
